// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit for the integer ALU datapath.
// Supports LSL, LSR, ASR, RLC and RRC with a start/busy/done handshake and
// registered result, carry-out and sticky overflow.
// Build option: define SEQ_SHIFT_BARREL_EN to collapse all shift steps into a
// single SHIFT cycle; results are bit-identical to the iterative build.

module seq_shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] abus,
  input  logic [AMT_W-1:0] amount,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outbus,
  output logic             cout,
  output logic             overflow
);

  localparam logic [2:0] OP_LSL = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_RLC = 3'b100;
  localparam logic [2:0] OP_RRC = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // One bit-step of the selected operation; returns {a, c, ovf}.
  function automatic logic [WIDTH+1:0] shift_step(
    input logic [2:0]       sop,
    input logic [WIDTH-1:0] a,
    input logic             c,
    input logic             ovf
  );
    logic [WIDTH-1:0] a_n;
    logic             c_n;
    logic             o_n;
    case (sop)
      OP_LSL: begin
        a_n = {a[WIDTH-2:0], 1'b0};
        c_n = a[WIDTH-1];
        o_n = ovf | (a[WIDTH-1] ^ a[WIDTH-2]);
      end
      OP_LSR: begin
        a_n = {1'b0, a[WIDTH-1:1]};
        c_n = a[0];
        o_n = ovf | a[WIDTH-1];
      end
      OP_ASR: begin
        a_n = {a[WIDTH-1], a[WIDTH-1:1]};
        c_n = a[0];
        o_n = ovf;
      end
      OP_RLC: begin
        a_n = {a[WIDTH-2:0], c};
        c_n = a[WIDTH-1];
        o_n = ovf | (a[WIDTH-1] ^ a[WIDTH-2]);
      end
      OP_RRC: begin
        a_n = {c, a[WIDTH-1:1]};
        c_n = a[0];
        o_n = ovf | (a[WIDTH-1] ^ c);
      end
      default: begin
        a_n = a;
        c_n = c;
        o_n = ovf;
      end
    endcase
    return {a_n, c_n, o_n};
  endfunction

  // True for the five operations that actually shift.
  function automatic logic op_is_shift(input logic [2:0] o);
    logic v;
    case (o)
      OP_LSL, OP_LSR, OP_ASR, OP_RLC, OP_RRC: v = 1'b1;
      default:                                v = 1'b0;
    endcase
    return v;
  endfunction

  // True for the rotates that start from the caller's carry-in.
  function automatic logic op_uses_cin(input logic [2:0] o);
    logic v;
    case (o)
      OP_RLC, OP_RRC: v = 1'b1;
      default:        v = 1'b0;
    endcase
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] outbus_q, outbus_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH+1:0] acc_s;
  logic             last_step_s;

`ifdef SEQ_SHIFT_BARREL_EN
  localparam int MAX_AMT = (1 << AMT_W) - 1;

  // Apply all count_q steps in one cycle by chaining the single-step function.
  always_comb begin
    acc_s = {a_q, c_q, ovf_q};
    for (int i = 0; i < MAX_AMT; i++) begin
      acc_s = (i < int'(count_q)) ? shift_step(op_q, acc_s[WIDTH+1:2], acc_s[1], acc_s[0])
                                  : acc_s;
    end
  end

  assign last_step_s = 1'b1;
`else
  // Apply exactly one step per SHIFT cycle.
  always_comb begin
    acc_s = shift_step(op_q, a_q, c_q, ovf_q);
  end

  assign last_step_s = (count_q == AMT_W'(1));
`endif

  // Next-state and next-output computation for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    c_d        = c_q;
    ovf_d      = ovf_q;
    op_d       = op_q;
    count_d    = count_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    outbus_d   = outbus_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          count_d = amount;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          if (op_is_shift(op)) begin
            a_d = abus;
            c_d = op_uses_cin(op) ? cin : 1'b0;
          end else begin
            a_d = {WIDTH{1'b0}};
            c_d = 1'b0;
          end
          if (op_is_shift(op) && (amount != {AMT_W{1'b0}})) begin
            state_d = ST_SHIFT;
          end else begin
            // No steps to take: publish the pass-through (or zero) result now.
            state_d    = ST_DONE;
            done_d     = 1'b1;
            outbus_d   = op_is_shift(op) ? abus : {WIDTH{1'b0}};
            cout_d     = 1'b0;
            overflow_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        a_d   = acc_s[WIDTH+1:2];
        c_d   = acc_s[1];
        ovf_d = acc_s[0];
        if (last_step_s) begin
          // Results are published on the edge that enters DONE.
          count_d    = {AMT_W{1'b0}};
          state_d    = ST_DONE;
          done_d     = 1'b1;
          outbus_d   = acc_s[WIDTH+1:2];
          cout_d     = acc_s[1];
          overflow_d = acc_s[0];
        end else begin
          count_d = count_q - AMT_W'(1);
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= {WIDTH{1'b0}};
      c_q        <= 1'b0;
      ovf_q      <= 1'b0;
      op_q       <= 3'b000;
      count_q    <= {AMT_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      outbus_q   <= {WIDTH{1'b0}};
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      c_q        <= c_d;
      ovf_q      <= ovf_d;
      op_q       <= op_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      outbus_q   <= outbus_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign outbus   = outbus_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed self-checking bench for seq_shift_unit (WIDTH=16, AMT_W=4).

module tb_seq_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] abus;
  logic [3:0]  amount;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] outbus;
  logic        cout;
  logic        overflow;

  int total;
  int bad;

  seq_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .abus     (abus),
    .amount   (amount),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .outbus   (outbus),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Expected done cycle (edge 0 = accepting edge) for a given step count.
  function automatic int exp_cyc(input int n);
`ifdef SEQ_SHIFT_BARREL_EN
    return (n == 0) ? 1 : 2;
`else
    return n + 1;
`endif
  endfunction

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [3:0] n, input logic ci);
    @(negedge clk);
    start = 1'b1; op = o; abus = a; amount = n; cin = ci;
  endtask

  // Waits for done; scrambles the don't-care inputs after the accepting edge.
  task automatic wait_done(output int cyc, output bit seen, output bit busy_ok);
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; op = 3'b111; abus = 16'hA5A5; amount = 4'hF; cin = 1'b1;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, outbus, cout, overflow} !== 20'h0) begin bad++; $display("FAIL reset_held got=%h exp=0", {busy, done, outbus, cout, overflow}); end
    reset = 1'b0;
    @(negedge clk);
    total++; if ({busy, done, outbus, cout, overflow} !== 20'h0) begin bad++; $display("FAIL reset_released got=%h exp=0", {busy, done, outbus, cout, overflow}); end
  endtask

  task automatic test_lsl();
    int cyc; bit seen; bit bok;
    issue(3'b001, 16'h4001, 4'd1, 1'b0);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(1)) begin bad++; $display("FAIL lsl_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(1)); end
    total++; if (!bok) begin bad++; $display("FAIL lsl_busy got=0 exp=1"); end
    total++; if (outbus !== 16'h8002) begin bad++; $display("FAIL lsl_out got=%h exp=8002", outbus); end
    total++; if (cout !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL lsl_flags got=%b%b exp=01", cout, overflow); end
  endtask

  task automatic test_abort();
    int abort_cyc; bit early; bit extra;
`ifdef SEQ_SHIFT_BARREL_EN
    abort_cyc = 1;
`else
    abort_cyc = 4;
`endif
    early = 1'b0;
    issue(3'b001, 16'h0001, 4'd10, 1'b0);
    for (int k = 1; k <= abort_cyc; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) early = 1'b1;
    end
    total++; if (early || outbus !== 16'h8002) begin bad++; $display("FAIL abort_pre got=%h early=%0d exp=8002", outbus, early); end
    reset = 1'b1;
    #1;
    total++; if ({busy, done, outbus, cout, overflow} !== 20'h0) begin bad++; $display("FAIL abort_outputs got=%h exp=0", {busy, done, outbus, cout, overflow}); end
    @(negedge clk);
    reset = 1'b0;
    extra = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    total++; if (extra) begin bad++; $display("FAIL abort_no_done got=1 exp=0"); end
  endtask

  task automatic test_lsr();
    int cyc; bit seen; bit bok;
    issue(3'b010, 16'h8F0F, 4'd4, 1'b0);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(4)) begin bad++; $display("FAIL lsr_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(4)); end
    total++; if (!bok) begin bad++; $display("FAIL lsr_busy got=0 exp=1"); end
    total++; if (outbus !== 16'h08F0) begin bad++; $display("FAIL lsr_out got=%h exp=08f0", outbus); end
    total++; if (cout !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL lsr_flags got=%b%b exp=11", cout, overflow); end
  endtask

  task automatic test_asr();
    int cyc; bit seen; bit bok;
    issue(3'b011, 16'h8000, 4'd15, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(15)) begin bad++; $display("FAIL asr15_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(15)); end
    total++; if (outbus !== 16'hFFFF) begin bad++; $display("FAIL asr15_out got=%h exp=ffff", outbus); end
    total++; if (cout !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL asr15_flags got=%b%b exp=00", cout, overflow); end
    issue(3'b011, 16'hFFFF, 4'd3, 1'b0);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(3)) begin bad++; $display("FAIL asr3_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(3)); end
    total++; if (outbus !== 16'hFFFF) begin bad++; $display("FAIL asr3_out got=%h exp=ffff", outbus); end
    total++; if (cout !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL asr3_flags got=%b%b exp=10", cout, overflow); end
  endtask

  task automatic test_rotate();
    int cyc; bit seen; bit bok;
    issue(3'b100, 16'h8001, 4'd2, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(2)) begin bad++; $display("FAIL rlc_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(2)); end
    total++; if (outbus !== 16'h0007) begin bad++; $display("FAIL rlc_out got=%h exp=0007", outbus); end
    total++; if (cout !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL rlc_flags got=%b%b exp=01", cout, overflow); end
    issue(3'b101, 16'h0001, 4'd1, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(1)) begin bad++; $display("FAIL rrc_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(1)); end
    total++; if (outbus !== 16'h8000) begin bad++; $display("FAIL rrc_out got=%h exp=8000", outbus); end
    total++; if (cout !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL rrc_flags got=%b%b exp=11", cout, overflow); end
  endtask

  task automatic test_amount_zero();
    int cyc; bit seen; bit bok;
    issue(3'b001, 16'h1234, 4'd0, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(0)) begin bad++; $display("FAIL amt0_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(0)); end
    total++; if (outbus !== 16'h1234) begin bad++; $display("FAIL amt0_out got=%h exp=1234", outbus); end
    total++; if (cout !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL amt0_flags got=%b%b exp=00", cout, overflow); end
  endtask

  task automatic test_reserved();
    int cyc; bit seen; bit bok;
    issue(3'b110, 16'hFFFF, 4'd5, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(0)) begin bad++; $display("FAIL rsvd_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(0)); end
    total++; if ({outbus, cout, overflow} !== 18'h0) begin bad++; $display("FAIL rsvd_out got=%h exp=0", {outbus, cout, overflow}); end
    issue(3'b000, 16'h5555, 4'd3, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(0) || {outbus, cout, overflow} !== 18'h0) begin bad++; $display("FAIL nop_out got=%h cyc=%0d exp=0", {outbus, cout, overflow}, cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; bit bok;
    issue(3'b101, 16'h0001, 4'd1, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || outbus !== 16'h8000) begin bad++; $display("FAIL b2b_first got=%h exp=8000", outbus); end
    issue(3'b100, 16'h8001, 4'd2, 1'b1);
    wait_done(cyc, seen, bok);
    total++; if (!seen || cyc != exp_cyc(2)) begin bad++; $display("FAIL b2b_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(2)); end
    total++; if (outbus !== 16'h0007 || cout !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h %b%b exp=0007 01", outbus, cout, overflow); end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit seen; bit extra; bit mid_ok;
    issue(3'b010, 16'h8F0F, 4'd4, 1'b0);
    cyc = 0; seen = 1'b0; mid_ok = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && outbus !== 16'h0007) mid_ok = 1'b0;
      if (cyc == 2 && busy !== 1'b1) mid_ok = 1'b0;
      if (cyc == 2 || done === 1'b1) begin
        start = 1'b1; op = 3'b001; abus = 16'hFFFF; amount = 4'd1; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    total++; if (!mid_ok) begin bad++; $display("FAIL busy_hold got=%h exp=0007", outbus); end
    total++; if (!seen || cyc != exp_cyc(4)) begin bad++; $display("FAIL busy_cycle got=%0d seen=%0d exp=%0d", cyc, seen, exp_cyc(4)); end
    total++; if (outbus !== 16'h08F0 || cout !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL busy_result got=%h %b%b exp=08f0 11", outbus, cout, overflow); end
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    total++; if (extra || outbus !== 16'h08F0) begin bad++; $display("FAIL busy_no_queue got=%h extra=%0d exp=08f0", outbus, extra); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; op = 3'b000; abus = 16'h0000; amount = 4'd0; cin = 1'b0;
    test_reset();
    test_lsl();
    test_abort();
    test_lsr();
    test_asr();
    test_rotate();
    test_amount_zero();
    test_reserved();
    test_back_to_back();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle parametrised shift/rotate unit for the integer ALU datapath. It shifts a WIDTH-bit operand by a programmable amount using one bit-step per clock, or in a single step when the barrel option is compiled in. It supports logical/arithmetic shifts and rotate-through-carry, and reports the final carry and a sticky overflow flag. It uses a start/busy/done handshake so the ALU sequencer can issue shifts and collect registered results.

## Interface
- WIDTH, 16: operand/result width, ≥ 2
- AMT_W, 4: shift-amount width; maximum amount is 2^AMT_W − 1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  000 nop, 001 LSL, 010 LSR, 011 ASR, 100 RLC (rotate left through carry), 101 RRC (rotate right through carry), 110/111 reserved
- abus  in  WIDTH  operand
- amount  in  AMT_W  shift count
- cin  in  1  initial carry for RLC/RRC
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse; results valid
- outbus  out  WIDTH  registered result, held until the next accepted start
- cout  out  1  last bit shifted out
- overflow  out  1  sticky sign-change flag

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE and sets busy=0, done=0, outbus=0, cout=0, overflow=0, and internal count=0.
- IDLE with start=1:
  - Latch abus into the working register, op, amount into count, and the carry register (cin for RLC/RRC, otherwise 0).
  - Clear the sticky overflow.
  - Go to SHIFT if amount≠0 and op ∈ {001…101}; otherwise go to DONE.
- SHIFT: perform one step per cycle and decrement count. When count reaches 0 after a step, go to DONE.
- Per-step rules (a = working register before the step, c = carry register):
  - LSL: a ← {a[W-2:0],0}; c ← a[W-1]; ovf |= a[W-1]^a[W-2]
  - LSR: a ← {0,a[W-1:1]}; c ← a[0]; ovf |= a[W-1]
  - ASR: a ← {a[W-1],a[W-1:1]}; c ← a[0]; ovf unchanged (remains 0)
  - RLC: a ← {a[W-2:0],c}; c ← a[W-1]; ovf |= a[W-1]^a[W-2]
  - RRC: a ← {c,a[W-1:1]}; c ← a[0]; ovf |= a[W-1]^c
- DONE: drive done=1; copy the working register to outbus, the carry register to cout, and the sticky flag to overflow; go to IDLE.
- amount=0 with a valid shift op: outbus=abus, cout=0, overflow=0.
- op 000 or reserved: outbus=0, cout=0, overflow=0 regardless of amount.
- Start while busy (SHIFT or DONE) is ignored and does not queue.
- Start in the IDLE cycle that immediately follows DONE is accepted. Back-to-back throughput is amount+2 cycles per operation.
- Reset mid-operation aborts immediately. No done pulse is issued, and all outputs return to their reset values.

## Timing
- Start sampled at edge 0. busy=1 in cycles 1…amount+1. done=1 in cycle amount+1 (cycle 1 when there are no steps).
- outbus, cout and overflow change only on the edge entering DONE and are stable from the done cycle until the next accepted start's DONE.
- Inputs abus, op, amount and cin are don't-care after the accepting edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SEQ_SHIFT_BARREL_EN defined:
  - SHIFT lasts exactly one cycle and applies all `amount` steps combinationally in that cycle.
  - The final a, c and sticky ovf must be bit-identical to the iterative result.
  - done arrives in cycle 2 for any nonzero amount (cycle 1 for amount=0/nop).
- Undefined: the iterative one-step-per-cycle behaviour described above.
- The handshake and the result values are the same in both builds.

## Test plan
All cases use WIDTH=16, AMT_W=4 unless noted.
- Reset/abort:
  - Assert reset → all outputs 0.
  - Start LSL amount 10; assert reset at cycle 4 → no done pulse, outputs 0, IDLE; a later start works normally.
- LSL, abus=0x4001, amount=1 → outbus=0x8002, cout=0, overflow=1; done in cycle 2.
- LSR, abus=0x8F0F, amount=4 → outbus=0x08F0, cout=1, overflow=1; done in cycle 5.
- ASR:
  - abus=0x8000, amount=15 → outbus=0xFFFF, cout=0, overflow=0.
  - abus=0xFFFF, amount=3 → 0xFFFF, cout=1, overflow=0.
- Rotate through carry:
  - RLC, abus=0x8001, cin=1, amount=2 → outbus=0x0007, cout=0, overflow=1.
  - RRC, abus=0x0001, cin=1, amount=1 → outbus=0x8000, cout=1, overflow=1.
- Handshake edges:
  - amount=0 with LSL and abus=0x1234 → outbus=0x1234, cout=0, overflow=0; done in cycle 1.
  - op=110 → all outputs 0.
  - A second start while busy is ignored.
  - Start in the cycle after DONE is accepted.
